vga_stream_aligner: RTL and testbench
=====================================

Name: vga_stream_aligner

Overview:
- Downstream of the 3x3 convolution stage; sits between the convolution output stream and the VGA RGB drive.
- Buffers convolved pixels in a FIFO and locks the stream's start-of-packet to the VGA frame start.
- Releases one pixel per visible VGA cycle, which removes pipeline-latency skew between the filter chain and the raster.
- Detects underflow and frame misalignment, flushes and resynchronises automatically.

Parameters:
- DATA_W, 8, pixel width.
- DEPTH, 2048, FIFO entries; power of two, at least 4.
- PREFILL, 1024, minimum FIFO level before streaming may start; 1 to DEPTH.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  convolved pixel.
- startofpacket_in  input  1  first pixel of frame, qualified by valid_in.
- endofpacket_in  input  1  last pixel of frame; accepted and ignored.
- valid_in  input  1  upstream data valid.
- ready_out  output  1  upstream may transfer this cycle.
- visible  input  1  VGA active-video cycle; pixel request.
- frame_start  input  1  one-cycle pulse coincident with the first visible cycle of a frame.
- data_out  output  DATA_W  registered pixel to VGA.
- valid_out  output  1  data_out holds a real pixel.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- state_out  output  2  current state: 00 IDLE, 01 FILL, 10 STREAM.
- error_count  output  16  underflow plus misalignment events, saturating at 0xFFFF.

Behaviour:
- Reset (synchronous, checked at a clk edge):
  - data_out=0, valid_out=0, level=0, state=IDLE, error_count=0, FIFO pointers=0.
  - ready_out=0 while reset is high.
- FIFO word = {sop, data}.
  - Push when valid_in && ready_out, except in the discard and flush cases below.
  - ready_out = !reset && (level != DEPTH). It does not depend on a same-cycle pop.
  - Pointers wrap modulo DEPTH. level = push_count - pop_count, range 0..DEPTH.
  - Simultaneous push and pop when not full: level unchanged.
- IDLE:
  - ready_out behaves as above.
  - Accepted words with sop=0 are discarded (not stored).
  - The first accepted word with sop=1 is stored; next state FILL.
- FILL:
  - Store all accepted words. No pops.
  - If frame_start && level >= PREFILL: go to STREAM, and this same cycle counts as the first pop.
  - frame_start while level < PREFILL: ignored; wait for the next frame.
- STREAM:
  - Each cycle with visible=1 pops the head word. On the next cycle data_out = head data and valid_out=1. Latency is exactly 1 clk from visible to data_out.
  - Cycles with visible=0: data_out=0, valid_out=0, no pop.
  - Underflow (visible=1 and level=0):
    - Next cycle data_out=0, valid_out=0.
    - error_count += 1 (saturating), FIFO flushed, state IDLE.
  - Misalignment (popped word sop != frame_start):
    - Pixel is not presented: next cycle data_out=0, valid_out=0.
    - error_count += 1, flush, state IDLE.
  - The FILL-to-STREAM first pop also applies the misalignment check. The head is always sop=1, so the check passes.
- Flush:
  - Pointers and level are zeroed in one cycle.
  - An input transfer in the flush cycle is dropped.
  - ready_out reflects the pre-flush level in that cycle.
- Reset mid-operation overrides every state and event.
- Push into an empty FIFO is not bypassed to a same-cycle pop; that case is treated as underflow.
- state_out mirrors the state register. Encoding 11 is unused; if reached, the next state is IDLE.

Test Plan (bench parameters DEPTH=16, PREFILL=4):
1. Reset: hold reset 3 cycles with valid_in=1 -> ready_out=0, data_out=0, valid_out=0, level=0, state_out=00, error_count=0. First cycle after release: ready_out=1.
2. Pre-SOP discard: push 0x01..0x05 with sop=0, then 0x10 with sop=1, then 0x11 -> level=2, state_out=01.
3. Start and stream: push 0x10..0x17 (sop on 0x10), then assert frame_start+visible for 1 cycle and visible for 7 more -> state_out=10; data_out=0x10..0x17 on consecutive cycles, each 1 cycle after its request, valid_out=1; level ends at 0.
4. Underflow: continue visible=1 for a 9th cycle -> next cycle valid_out=0, data_out=0, error_count=1, state_out=00, level=0.
5. Misalignment: stream 0x10..0x13 (sop on 0x10, 0x12 also sop=1), frame_start only on the first cycle -> on popping 0x12, valid_out=0, error_count increments by 1, state_out=00, level=0.
6. Backpressure: in FILL with no frame_start, push 20 words -> ready_out=0 once level=16; words 17..20 are not stored; level stays 16. Then frame_start+visible -> first pop; the following cycle ready_out=1 and level=15.

Source files
------------

// File: rtl/vga_stream_aligner.sv
// vga_stream_aligner: elastic FIFO between the 3x3 convolution output and the
// VGA RGB drive. It locks the stream's start-of-packet to the VGA frame start,
// releases one pixel per visible cycle, and flushes/resynchronises on underflow
// or misalignment.
module vga_stream_aligner #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 2048,
  parameter int PREFILL = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   startofpacket_in,
  input  logic                   endofpacket_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic                   visible,
  input  logic                   frame_start,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic [$clog2(DEPTH):0] level,
  output logic [1:0]             state_out,
  output logic [15:0]            error_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL    = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    STREAM = 2'b10
  } state_e;

  // Saturating increment for the event counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Storage: each word is {sop, pixel}.
  logic [DATA_W:0]     mem_q [DEPTH];

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic [15:0]         err_q, err_d;

  logic                accept;
  logic                push_en;
  logic                pop_en;
  logic                flush;
  logic                err_evt;
  logic                present;
  logic [DATA_W:0]     head_word;
  logic                head_sop;
  logic [DATA_W-1:0]   head_data;

  // End-of-packet carries no information for raster alignment.
  logic unused_eop;
  assign unused_eop = endofpacket_in;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-cycle event decode: which words are stored, popped, presented, or
  // trigger a flush. A pop from an empty FIFO is never bypassed from input.
  always_comb begin
    accept    = valid_in && ready_out;
    head_word = mem_q[rd_ptr_q];
    head_sop  = head_word[DATA_W];
    head_data = head_word[DATA_W-1:0];
    push_en   = 1'b0;
    pop_en    = 1'b0;
    flush     = 1'b0;
    err_evt   = 1'b0;
    present   = 1'b0;
    case (state_q)
      IDLE: begin
        push_en = accept && startofpacket_in;
      end
      FILL: begin
        push_en = accept;
        if (frame_start && (level_q >= PREFILL_LVL)) begin
          pop_en = 1'b1;
          if (head_sop != frame_start) begin
            flush   = 1'b1;
            err_evt = 1'b1;
          end else begin
            present = 1'b1;
          end
        end
      end
      STREAM: begin
        push_en = accept;
        if (visible) begin
          if (level_q == '0) begin
            flush   = 1'b1;
            err_evt = 1'b1;
          end else begin
            pop_en = 1'b1;
            if (head_sop != frame_start) begin
              flush   = 1'b1;
              err_evt = 1'b1;
            end else begin
              present = 1'b1;
            end
          end
        end
      end
      default: begin
      end
    endcase
    // An input transfer coinciding with a flush is dropped.
    if (flush) begin
      push_en = 1'b0;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push_en) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (pop_en) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (flush) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: state mirror and upstream flow control.
  always_comb begin
    state_out = state_q;
    ready_out = !reset && (level_q != FULL_LVL);
  end

  // Pointer, level, pixel and error-count next values.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(push_en);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop_en);
    level_d     = level_q + LVL_W'(push_en) - LVL_W'(pop_en);
    data_out_d  = present ? head_data : '0;
    valid_out_d = present;
    err_d       = err_evt ? sat_inc16(err_q) : err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Registered FIFO control, output pixel and error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      err_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= {startofpacket_in, data_in};
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign level       = level_q;
  assign error_count = err_q;

endmodule

// File: tb/tb_vga_stream_aligner.sv
// Self-checking bench for vga_stream_aligner: directed vector table, a
// backpressure sequence, then randomized traffic against a queue-based model.
module tb_vga_stream_aligner;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int PREFILL = 4;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              startofpacket_in;
  logic              endofpacket_in;
  logic              valid_in;
  logic              ready_out;
  logic              visible;
  logic              frame_start;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [4:0]        level;
  logic [1:0]        state_out;
  logic [15:0]       error_count;

  int checks;
  int errors;

  vga_stream_aligner #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PREFILL(PREFILL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .startofpacket_in(startofpacket_in),
    .endofpacket_in  (endofpacket_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .visible         (visible),
    .frame_start     (frame_start),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .level           (level),
    .state_out       (state_out),
    .error_count     (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         vin;
    bit         sop;
    logic [7:0] din;
    bit         vis;
    bit         fs;
    bit         e_rdy;
    logic [7:0] e_dout;
    bit         e_vout;
    int         e_lvl;
    logic [1:0] e_st;
    int         e_err;
  } vec_t;

  vec_t vt[$];

  typedef struct packed {
    logic       sop;
    logic [7:0] d;
  } word_t;

  // Reference model: FIFO contents as a queue plus a mode number.
  word_t      mq[$];
  int         m_mode;
  logic [7:0] m_dout;
  bit         m_vout;
  int         m_err;

  task automatic addv(input bit rst, input bit vin, input bit sop, input logic [7:0] din,
                      input bit vis, input bit fs, input bit e_rdy, input logic [7:0] e_dout,
                      input bit e_vout, input int e_lvl, input logic [1:0] e_st, input int e_err);
    vec_t v;
    v.rst = rst; v.vin = vin; v.sop = sop; v.din = din; v.vis = vis; v.fs = fs;
    v.e_rdy = e_rdy; v.e_dout = e_dout; v.e_vout = e_vout; v.e_lvl = e_lvl;
    v.e_st = e_st; v.e_err = e_err;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit vin, input bit sop, input logic [7:0] din,
                       input bit vis, input bit fs);
    reset = rst; valid_in = vin; startofpacket_in = sop; data_in = din;
    visible = vis; frame_start = fs; endofpacket_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input bit e_rdy, input logic [7:0] e_dout,
                           input bit e_vout, input int e_lvl, input logic [1:0] e_st, input int e_err);
    chk("ready_out",   idx, {31'd0, ready_out}, {31'd0, e_rdy});
    chk("data_out",    idx, {24'd0, data_out},  {24'd0, e_dout});
    chk("valid_out",   idx, {31'd0, valid_out}, {31'd0, e_vout});
    chk("level",       idx, {27'd0, level},     e_lvl);
    chk("state_out",   idx, {30'd0, state_out}, {30'd0, e_st});
    chk("error_count", idx, {16'd0, error_count}, e_err);
  endtask

  task automatic model_step(input bit r, input bit vin, input bit sop, input logic [7:0] din,
                            input bit vis, input bit fs);
    bit    rdy;
    bit    flush;
    int    next_mode;
    word_t w;
    if (r) begin
      mq.delete();
      m_mode = 0; m_dout = '0; m_vout = 1'b0; m_err = 0;
      return;
    end
    rdy       = (mq.size() != DEPTH);
    flush     = 1'b0;
    m_dout    = '0;
    m_vout    = 1'b0;
    next_mode = m_mode;
    if ((m_mode == 1 && fs && mq.size() >= PREFILL) || (m_mode == 2 && vis)) begin
      if (mq.size() == 0) begin
        flush = 1'b1;
      end else begin
        w = mq.pop_front();
        if (w.sop != fs) begin
          flush = 1'b1;
        end else begin
          m_dout = w.d; m_vout = 1'b1; next_mode = 2;
        end
      end
    end
    if (flush) begin
      mq.delete();
      if (m_err < 65535) m_err++;
      m_mode = 0;
    end else begin
      if (vin && rdy && (m_mode != 0 || sop)) begin
        mq.push_back({sop, din});
        if (m_mode == 0) next_mode = 1;
      end
      m_mode = next_mode;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);

    // Reset held with valid_in high.
    for (int i = 0; i < 3; i++) addv(1,1,0,8'hAA,0,0, 0,8'h00,0,0,2'b00,0);
    // Release: upstream may transfer immediately.
    addv(0,0,0,8'h00,0,0, 1,8'h00,0,0,2'b00,0);
    // Words before the first sop are discarded.
    for (int i = 1; i <= 5; i++) addv(0,1,0,8'(i),0,0, 1,8'h00,0,0,2'b00,0);
    addv(0,1,1,8'h10,0,0, 1,8'h00,0,1,2'b01,0);
    addv(0,1,0,8'h11,0,0, 1,8'h00,0,2,2'b01,0);
    // frame_start below PREFILL is ignored.
    addv(0,0,0,8'h00,1,1, 1,8'h00,0,2,2'b01,0);
    for (int i = 2; i <= 7; i++) addv(0,1,0,8'(8'h10 + i),0,0, 1,8'h00,0,i+1,2'b01,0);
    // First pop on frame_start, then seven visible pops.
    addv(0,0,0,8'h00,1,1, 1,8'h10,1,7,2'b10,0);
    for (int i = 1; i <= 7; i++) addv(0,0,0,8'h00,1,0, 1,8'(8'h10 + i),1,7-i,2'b10,0);
    // Ninth request on an empty FIFO is an underflow.
    addv(0,0,0,8'h00,1,0, 1,8'h00,0,0,2'b00,1);
    // Misalignment: 0x12 carries sop while frame_start is low.
    addv(0,1,1,8'h10,0,0, 1,8'h00,0,1,2'b01,1);
    addv(0,1,0,8'h11,0,0, 1,8'h00,0,2,2'b01,1);
    addv(0,1,1,8'h12,0,0, 1,8'h00,0,3,2'b01,1);
    addv(0,1,0,8'h13,0,0, 1,8'h00,0,4,2'b01,1);
    addv(0,0,0,8'h00,1,1, 1,8'h10,1,3,2'b10,1);
    addv(0,0,0,8'h00,0,0, 1,8'h00,0,3,2'b10,1);
    // Simultaneous push and pop keeps the level.
    addv(0,1,0,8'h20,1,0, 1,8'h11,1,3,2'b10,1);
    // Misaligned pop flushes; the sop push in that cycle is dropped.
    addv(0,1,1,8'h21,1,0, 1,8'h00,0,0,2'b00,2);
    addv(0,0,0,8'h00,0,0, 1,8'h00,0,0,2'b00,2);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].vin, vt[i].sop, vt[i].din, vt[i].vis, vt[i].fs);
      tick();
      check_all(i, vt[i].e_rdy, vt[i].e_dout, vt[i].e_vout, vt[i].e_lvl, vt[i].e_st, vt[i].e_err);
    end

    // Backpressure: 20 offered words, only 16 fit.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, (i == 0), 8'(8'h40 + i), 1'b0, 1'b0);
      tick();
      check_all(100 + i, (i < 15), 8'h00, 1'b0, (i < 16) ? i + 1 : 16, 2'b01, 2);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    check_all(120, 1'b1, 8'h40, 1'b1, 15, 2'b10, 2);
    // Drain: the 16 stored words are exactly 0x40..0x4F.
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      check_all(120 + i, 1'b1, 8'(8'h40 + i), 1'b1, 15 - i, 2'b10, 2);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_all(136, 1'b1, 8'h00, 1'b0, 0, 2'b00, 3);

    // Randomized traffic against the reference model.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    model_step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4000; c++) begin
      bit         r, vin, sop, vis, fs;
      logic [7:0] din;
      r   = ($urandom_range(0, 299) == 0);
      vin = ($urandom_range(0, 3) != 0);
      sop = ($urandom_range(0, 9) == 0);
      din = 8'($urandom_range(0, 255));
      vis = ($urandom_range(0, 4) != 0);
      fs  = vis && ($urandom_range(0, 11) == 0);
      drive(r, vin, sop, din, vis, fs);
      model_step(r, vin, sop, din, vis, fs);
      tick();
      check_all(1000 + c, !r && (mq.size() != DEPTH), m_dout, m_vout, mq.size(),
                2'(m_mode), m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
